// File: rtl/fc_sequencer.sv
// Sequencer for one pass of the 10-lane FC MAC/argmax datapath: clear, stream, drain, capture.
// Optional cycle counter output perf_cycles is built when FC_SEQ_PERF_EN is defined.
module fc_sequencer #(
    parameter int N_IN   = 16,
    parameter int RD_LAT = 1,
    parameter int AW     = $clog2(N_IN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    input  logic          feat_avail,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          acc_clr,
    output logic          acc_en,
    input  logic [3:0]    class_idx,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [3:0]    res_class,
`ifdef FC_SEQ_PERF_EN
    output logic [15:0]   perf_cycles,
`endif
    output logic [2:0]    dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_RESULT = 3'd5;

    localparam logic [AW-1:0] IDX_LAST   = AW'(N_IN - 1);
    localparam logic [2:0]    DRAIN_LAST = 3'(RD_LAT - 1);

    // Result interface: res_valid stays high in RESULT until a cycle with res_ready;
    // the transfer completes on that edge and res_class is stable while res_valid is high.

    logic [2:0]        state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [2:0]        drain_q, drain_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [3:0]        res_class_q, res_class_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        drain_d     = drain_q;
        res_class_d = res_class_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                idx_d   = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // The index holds at its last value on exit so it never wraps.
                if (feat_avail) begin
                    if (idx_q == IDX_LAST) begin
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = S_SETTLE;
                else                       drain_d = drain_q + 3'd1;
            end
            S_SETTLE: begin
                res_class_d = class_idx;
                state_d     = S_RESULT;
            end
            S_RESULT: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_en = (state_q == S_ISSUE) && feat_avail;

    // acc_en follows rd_en by the memory read latency.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = rd_en;
        for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            drain_q     <= '0;
            pipe_q      <= '0;
            res_class_q <= 4'hF;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            drain_q     <= drain_d;
            pipe_q      <= pipe_d;
            res_class_q <= res_class_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign acc_clr   = (state_q == S_CLEAR);
    assign acc_en    = pipe_q[RD_LAT-1];
    assign rd_addr   = idx_q;
    assign res_valid = (state_q == S_RESULT);
    assign res_class = res_class_q;
    assign dbg_state = state_q;

`ifdef FC_SEQ_PERF_EN
    logic [15:0] perf_cnt_q, perf_cnt_d;
    logic [15:0] perf_out_q, perf_out_d;
    logic [15:0] perf_inc;

    // Counts CLEAR through SETTLE inclusive, saturating; published on entry to RESULT.
    always_comb begin
        perf_inc   = (perf_cnt_q == 16'hFFFF) ? perf_cnt_q : perf_cnt_q + 16'd1;
        perf_cnt_d = perf_cnt_q;
        perf_out_d = perf_out_q;
        case (state_q)
            S_CLEAR:          perf_cnt_d = 16'd1;
            S_ISSUE, S_DRAIN: perf_cnt_d = perf_inc;
            S_SETTLE: begin
                perf_cnt_d = perf_inc;
                perf_out_d = perf_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt_q <= '0;
            perf_out_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
            perf_out_q <= perf_out_d;
        end
    end

    assign perf_cycles = perf_out_q;
`endif

endmodule

// File: tb/tb_fc_sequencer.sv
// Directed bench for fc_sequencer: two instances (RD_LAT=1 and RD_LAT=3) checked cycle by cycle.
module tb_fc_sequencer;

    localparam int N_IN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    logic       feat_avail = 1'b0;
    logic       res_ready = 1'b0;
    logic [3:0] class_idx = 4'd0;
    logic       sel = 1'b0;

    logic       busy1, rd_en1, acc_clr1, acc_en1, res_valid1;
    logic [3:0] rd_addr1, res_class1;
    logic [2:0] dbg1;
    logic       busy3, rd_en3, acc_clr3, acc_en3, res_valid3;
    logic [3:0] rd_addr3, res_class3;
    logic [2:0] dbg3;

    logic       o_busy, o_rd_en, o_acc_clr, o_acc_en, o_res_valid;
    logic [3:0] o_rd_addr, o_res_class;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef FC_SEQ_PERF_EN
    logic [15:0] perf1, perf3, o_perf;
    assign o_perf = sel ? perf3 : perf1;
`endif

    fc_sequencer #(.N_IN(N_IN), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1),
        .feat_avail(feat_avail), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .acc_clr(acc_clr1), .acc_en(acc_en1), .class_idx(class_idx),
        .res_valid(res_valid1), .res_ready(res_ready), .res_class(res_class1),
`ifdef FC_SEQ_PERF_EN
        .perf_cycles(perf1),
`endif
        .dbg_state(dbg1)
    );

    fc_sequencer #(.N_IN(N_IN), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3),
        .feat_avail(feat_avail), .rd_en(rd_en3), .rd_addr(rd_addr3),
        .acc_clr(acc_clr3), .acc_en(acc_en3), .class_idx(class_idx),
        .res_valid(res_valid3), .res_ready(res_ready), .res_class(res_class3),
`ifdef FC_SEQ_PERF_EN
        .perf_cycles(perf3),
`endif
        .dbg_state(dbg3)
    );

    assign o_busy      = sel ? busy3      : busy1;
    assign o_rd_en     = sel ? rd_en3     : rd_en1;
    assign o_rd_addr   = sel ? rd_addr3   : rd_addr1;
    assign o_acc_clr   = sel ? acc_clr3   : acc_clr1;
    assign o_acc_en    = sel ? acc_en3    : acc_en1;
    assign o_res_valid = sel ? res_valid3 : res_valid1;
    assign o_res_class = sel ? res_class3 : res_class1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, obs, exp_v, $time, sel);
        end
    endtask

    function automatic bit stalled(input int c, input int sa, input int slen);
        return (slen > 0) && (c >= sa + 2) && (c < sa + 2 + slen);
    endfunction

    task automatic check_idle_outputs(input logic [3:0] exp_class);
        check("idle_busy",      16'(o_busy),      16'd0);
        check("idle_rd_en",     16'(o_rd_en),     16'd0);
        check("idle_rd_addr",   16'(o_rd_addr),   16'd0);
        check("idle_acc_clr",   16'(o_acc_clr),   16'd0);
        check("idle_acc_en",    16'(o_acc_en),    16'd0);
        check("idle_res_valid", 16'(o_res_valid), 16'd0);
        check("idle_res_class", 16'(o_res_class), 16'(exp_class));
`ifdef FC_SEQ_PERF_EN
        check("idle_perf", o_perf, 16'd0);
`endif
    endtask

    // Called at the falling edge of cycle 0 with the selected instance idle.
    // Cycle 0 is the cycle whose closing edge samples start.
    task automatic run_pass(input int lat, input int sa, input int slen, input logic [3:0] cls,
                            input int hold, input bit keep_start, input bit skip_start);
        int         rv, hc, c_last, a, n_acc;
        bit         exp_rd[64];
        logic [3:0] exp_ad[64];
        bit         exp_acc;
        sel    = (lat == 3);
        rv     = N_IN + lat + 3 + slen;
        hc     = rv + hold;
        for (int i = 0; i < 64; i++) begin
            exp_rd[i] = 1'b0;
            exp_ad[i] = 4'd0;
        end
        a      = 0;
        c_last = 1;
        for (int c = 2; a < N_IN; c++) begin
            exp_ad[c] = 4'(a);
            exp_rd[c] = !stalled(c, sa, slen);
            if (exp_rd[c]) a++;
            c_last = c;
        end
        if (!skip_start) begin
            if (lat == 1) start1 = 1'b1;
            else          start3 = 1'b1;
        end
        n_acc = 0;
        for (int c = 1; c <= hc + 1; c++) begin
            @(posedge clk);
            #1;
            if (lat == 1) start1 = keep_start;
            else          start3 = keep_start;
            feat_avail = !stalled(c, sa, slen);
            class_idx  = (c == rv - 1) ? cls : ~cls;
            res_ready  = (c == hc) || ((c < rv - 1) && (c % 3 == 0));
            @(negedge clk);
            check("busy",    16'(o_busy),    16'(c <= hc));
            check("acc_clr", 16'(o_acc_clr), 16'(c == 1));
            check("rd_en",   16'(o_rd_en),   16'(exp_rd[c]));
            if (c >= 2 && c <= c_last) check("rd_addr", 16'(o_rd_addr), 16'(exp_ad[c]));
            exp_acc = (c - lat >= 2) ? exp_rd[c - lat] : 1'b0;
            check("acc_en",  16'(o_acc_en),  16'(exp_acc));
            if (o_acc_en) n_acc++;
            check("res_valid", 16'(o_res_valid), 16'((c >= rv) && (c <= hc)));
            if (c >= rv) check("res_class", 16'(o_res_class), 16'(cls));
`ifdef FC_SEQ_PERF_EN
            if (c >= rv) check("perf_cycles", o_perf, 16'(N_IN + 2 + lat + slen));
`endif
        end
        check("acc_count", 16'(n_acc), 16'(N_IN));
    endtask

    task automatic reset_mid_pass();
        sel    = 1'b0;
        start1 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            start1     = 1'b0;
            feat_avail = 1'b1;
            if (c == 10) rst = 1'b1;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs(4'hF);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post_rst_acc_en", 16'(o_acc_en), 16'd0);
            check("post_rst_busy",   16'(o_busy),   16'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        sel = 1'b0;
        check_idle_outputs(4'hF);
        sel = 1'b1;
        check_idle_outputs(4'hF);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);

        run_pass(1, 0, 0, 4'd7, 0, 1'b0, 1'b0);
        run_pass(1, 5, 3, 4'd2, 0, 1'b0, 1'b0);
        run_pass(3, 0, 0, 4'd9, 0, 1'b0, 1'b0);
        run_pass(1, 0, 0, 4'd4, 10, 1'b1, 1'b0);
        run_pass(1, 0, 0, 4'd11, 2, 1'b0, 1'b1);
        reset_mid_pass();
        run_pass(1, 0, 0, 4'd0, 1, 1'b0, 1'b0);
        run_pass(3, 2, 4, 4'd5, 3, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
